// File: rtl/core_sequencer_pkg.sv
// Shared opcode constants, FSM state encoding and opcode classification
// for the core sequencer.
package core_sequencer_pkg;

  localparam logic [6:0] RTYPE  = 7'b0110011;
  localparam logic [6:0] ITYPE  = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STYPE  = 7'b0100011;
  localparam logic [6:0] UJTYPE = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] BTYPE  = 7'b1100011;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  function automatic logic is_legal_op(input logic [6:0] op);
    case (op)
      RTYPE, ITYPE, LOAD, STYPE, UJTYPE,
      JALR, LUI, AUIPC, BTYPE, SYSTEM: is_legal_op = 1'b1;
      default:                         is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/core_sequencer_mem_watchdog.sv
// Wait-cycle counter for outstanding memory requests; flags a timeout when
// MEM_TIMEOUT cycles elapse without an acknowledge.
module mem_watchdog #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_active,
  input  logic i_ack,
  output logic o_timeout
);

  localparam int unsigned CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

  logic [CW-1:0] r_cnt;
  logic          w_hit;

  assign w_hit     = (r_cnt == CW'(MEM_TIMEOUT - 1));
  // An ack in the final cycle suppresses the timeout.
  assign o_timeout = i_active & ~i_ack & w_hit;

  // Idle or acknowledged cycles clear the count, so every new request starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_active || i_ack) begin
      r_cnt <= '0;
    end else if (!w_hit) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/memory/writeback
// control with sticky halt and trap, and a memory-ack watchdog.
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  input  logic [31:0] alu_result,
  input  logic        branch_taken,
  input  logic [31:0] target_addr,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic [31:0] instret,
  output logic        halt,
  output logic        trap
);

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_instret;
  logic [31:0] r_target;
  logic        r_imem_req;
  logic        r_dmem_req;
  logic        r_dmem_we;
  logic        r_rf_we;
  logic        r_halt;
  logic        r_trap;

  logic [6:0]  w_op;
  logic        w_rd_nz;
  logic        w_active;
  logic        w_ack;
  logic        w_timeout;
  logic        w_unused;

  assign w_op     = r_ir[6:0];
  assign w_rd_nz  = |r_ir[11:7];
  assign w_active = r_imem_req | r_dmem_req;
  assign w_ack    = (r_imem_req & imem_ack) | (r_dmem_req & dmem_ack);
  // The data address is consumed by the memory directly, not by the sequencer.
  assign w_unused = ^alu_result;

  mem_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_active (w_active),
    .i_ack    (w_ack),
    .o_timeout(w_timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_ir       <= '0;
      r_instret  <= '0;
      r_target   <= '0;
      r_imem_req <= 1'b0;
      r_dmem_req <= 1'b0;
      r_dmem_we  <= 1'b0;
      r_rf_we    <= 1'b0;
      r_halt     <= 1'b0;
      r_trap     <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          // Only the first fetch after reset arrives here with the request still low.
          if (!r_imem_req) begin
            r_imem_req <= 1'b1;
          end else if (imem_ack) begin
            r_ir       <= imem_rdata;
            r_imem_req <= 1'b0;
            r_state    <= S_DECODE;
          end else if (w_timeout) begin
            r_imem_req <= 1'b0;
            r_trap     <= 1'b1;
            r_state    <= S_STOP;
          end
        end

        S_DECODE: begin
          if (w_op == SYSTEM) begin
            r_halt  <= 1'b1;
            r_state <= S_STOP;
          end else if (!is_legal_op(w_op)) begin
            r_trap  <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_state <= S_EXEC;
          end
        end

        S_EXEC: begin
          r_target <= target_addr;
          case (w_op)
            LOAD, STYPE: begin
              r_dmem_req <= 1'b1;
              r_dmem_we  <= (w_op == STYPE);
              r_state    <= S_MEM;
            end
            BTYPE: begin
              if (branch_taken && (target_addr[1:0] != 2'b00)) begin
                r_trap  <= 1'b1;
                r_state <= S_STOP;
              end else begin
                r_pc       <= branch_taken ? target_addr : r_pc + 32'd4;
                r_instret  <= r_instret + 32'd1;
                r_imem_req <= 1'b1;
                r_state    <= S_FETCH;
              end
            end
            // Jump targets are checked here so a misaligned jump never strobes rf_we.
            UJTYPE, JALR: begin
              if (target_addr[1:0] != 2'b00) begin
                r_trap  <= 1'b1;
                r_state <= S_STOP;
              end else begin
                r_rf_we <= w_rd_nz;
                r_state <= S_WB;
              end
            end
            default: begin
              r_rf_we <= w_rd_nz;
              r_state <= S_WB;
            end
          endcase
        end

        S_MEM: begin
          if (dmem_ack) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            if (r_dmem_we) begin
              r_pc       <= r_pc + 32'd4;
              r_instret  <= r_instret + 32'd1;
              r_imem_req <= 1'b1;
              r_state    <= S_FETCH;
            end else begin
              r_rf_we <= w_rd_nz;
              r_state <= S_WB;
            end
          end else if (w_timeout) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_trap     <= 1'b1;
            r_state    <= S_STOP;
          end
        end

        S_WB: begin
          r_rf_we    <= 1'b0;
          r_pc       <= ((w_op == UJTYPE) || (w_op == JALR)) ? r_target : r_pc + 32'd4;
          r_instret  <= r_instret + 32'd1;
          r_imem_req <= 1'b1;
          r_state    <= S_FETCH;
        end

        default: begin
          r_imem_req <= 1'b0;
          r_dmem_req <= 1'b0;
          r_dmem_we  <= 1'b0;
          r_rf_we    <= 1'b0;
          r_state    <= S_STOP;
        end
      endcase
    end
  end

  assign imem_req  = r_imem_req;
  assign imem_addr = r_pc;
  assign instr     = r_ir;
  assign dmem_req  = r_dmem_req;
  assign dmem_we   = r_dmem_we;
  assign rf_we     = r_rf_we;
  assign pc        = r_pc;
  assign instret   = r_instret;
  assign halt      = r_halt;
  assign trap      = r_trap;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: hand-computed expectations checked with
// immediate assertions, sampled on the falling clock edge.
module tb_core_sequencer;
  import core_sequencer_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] alu_result;
  logic        branch_taken;
  logic [31:0] target_addr;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        rf_we;
  logic [31:0] pc;
  logic [31:0] instret;
  logic        halt;
  logic        trap;

  int unsigned n_pass;
  int unsigned n_total;

  localparam logic [31:0] W_ADDI  = 32'h0050_0093;
  localparam logic [31:0] W_BEQ   = 32'h0000_0463;
  localparam logic [31:0] W_LW    = 32'h0000_a103;
  localparam logic [31:0] W_SW    = 32'h0020_a023;
  localparam logic [31:0] W_JAL   = 32'h0000_00ef;
  localparam logic [31:0] W_LUI0  = 32'h0000_1037;
  localparam logic [31:0] W_ECALL = 32'h0000_0073;
  localparam logic [31:0] W_ILL   = 32'hffff_ffff;

  core_sequencer #(
    .RESET_PC   (32'h0000_0000),
    .MEM_TIMEOUT(255)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .alu_result  (alu_result),
    .branch_taken(branch_taken),
    .target_addr (target_addr),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_ack    (dmem_ack),
    .rf_we       (rf_we),
    .pc          (pc),
    .instret     (instret),
    .halt        (halt),
    .trap        (trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL sim_timeout: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called on a falling edge in FETCH with imem_req high; returns in DECODE.
  task automatic fetch(input logic [31:0] w);
    imem_ack   = 1'b1;
    imem_rdata = w;
    @(negedge clk);
    imem_ack   = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; alu_result = 32'h0000_0100;
    branch_taken = 1'b0; target_addr = '0; dmem_ack = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_dmem_req", {30'd0, dmem_req, dmem_we}, 32'd0);
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instret", instret, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_flags", {30'd0, halt, trap}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);

    // ADDI x1: rf_we in the fourth cycle, pc=4
    fetch(W_ADDI);
    chk("addi_req_drop", {31'd0, imem_req}, 32'd0);
    chk("addi_ir", instr, W_ADDI);
    @(negedge clk);
    chk("addi_exec_rfwe", {31'd0, rf_we}, 32'd0);
    @(negedge clk);
    chk("addi_wb_rfwe", {31'd0, rf_we}, 32'd1);
    chk("addi_wb_pc", pc, 32'h0);
    @(negedge clk);
    chk("addi_rfwe_off", {31'd0, rf_we}, 32'd0);
    chk("addi_pc", pc, 32'h4);
    chk("addi_instret", instret, 32'd1);
    chk("addi_next_addr", imem_addr, 32'h4);

    // BEQ taken to 0x40
    fetch(W_BEQ);
    branch_taken = 1'b1; target_addr = 32'h0000_0040;
    @(negedge clk);
    chk("beq_exec_rfwe", {31'd0, rf_we}, 32'd0);
    @(negedge clk);
    branch_taken = 1'b0;
    chk("beq_pc", pc, 32'h40);
    chk("beq_instret", instret, 32'd2);
    chk("beq_rfwe", {31'd0, rf_we}, 32'd0);

    // LW with ack in the fourth MEM cycle
    fetch(W_LW);
    @(negedge clk);
    chk("lw_exec_dreq", {31'd0, dmem_req}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) dmem_ack = 1'b1;
      chk("lw_dreq_held", {30'd0, dmem_req, dmem_we}, 32'b10);
    end
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("lw_wb_dreq", {31'd0, dmem_req}, 32'd0);
    chk("lw_wb_rfwe", {31'd0, rf_we}, 32'd1);
    @(negedge clk);
    chk("lw_rfwe_off", {31'd0, rf_we}, 32'd0);
    chk("lw_pc", pc, 32'h44);
    chk("lw_instret", instret, 32'd3);

    // SW with immediate ack: no writeback
    fetch(W_SW);
    @(negedge clk);
    @(negedge clk);
    chk("sw_dreq_we", {30'd0, dmem_req, dmem_we}, 32'b11);
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("sw_dreq_off", {31'd0, dmem_req}, 32'd0);
    chk("sw_rfwe", {31'd0, rf_we}, 32'd0);
    chk("sw_pc", pc, 32'h48);
    chk("sw_instret", instret, 32'd4);

    // JAL x1 to 0x100
    fetch(W_JAL);
    target_addr = 32'h0000_0100;
    @(negedge clk);
    @(negedge clk);
    chk("jal_rfwe", {31'd0, rf_we}, 32'd1);
    @(negedge clk);
    chk("jal_pc", pc, 32'h100);
    chk("jal_instret", instret, 32'd5);

    // LUI x0: writeback without rf_we
    fetch(W_LUI0);
    @(negedge clk);
    @(negedge clk);
    chk("lui_x0_rfwe", {31'd0, rf_we}, 32'd0);
    @(negedge clk);
    chk("lui_pc", pc, 32'h104);
    chk("lui_instret", instret, 32'd6);

    // BEQ taken to misaligned 0x42
    fetch(W_BEQ);
    branch_taken = 1'b1; target_addr = 32'h0000_0042;
    @(negedge clk);
    @(negedge clk);
    branch_taken = 1'b0;
    chk("mis_trap", {31'd0, trap}, 32'd1);
    chk("mis_pc", pc, 32'h104);
    chk("mis_instret", instret, 32'd6);
    chk("mis_state", 32'(dut.r_state), 32'(S_STOP));
    imem_ack = 1'b1;
    repeat (3) @(negedge clk);
    imem_ack = 1'b0;
    chk("stop_req", {29'd0, imem_req, dmem_req, rf_we}, 32'd0);
    chk("stop_pc", pc, 32'h104);

    // Reset clears trap; illegal opcode traps
    do_reset();
    chk("rst2_pc", pc, 32'h0);
    chk("rst2_flags", {30'd0, halt, trap}, 32'd0);
    fetch(W_ILL);
    @(negedge clk);
    chk("ill_trap", {30'd0, halt, trap}, 32'b01);
    chk("ill_instret", instret, 32'd0);

    // ECALL halts, reset clears halt
    do_reset();
    fetch(W_ECALL);
    @(negedge clk);
    chk("ecall_flags", {30'd0, halt, trap}, 32'b10);
    chk("ecall_instret", instret, 32'd0);
    chk("ecall_req", {31'd0, imem_req}, 32'd0);
    do_reset();
    chk("ecall_rst_halt", {31'd0, halt}, 32'd0);
    chk("ecall_rst_pc", pc, 32'h0);

    // Reset during a pending load
    fetch(W_LW);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_dreq_before", {31'd0, dmem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_dreq", {31'd0, dmem_req}, 32'd0);
    chk("midrst_rfwe_instret", {rf_we, instret[30:0]}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_pc", pc, 32'h0);

    // Ack in the last cycle before timeout wins
    repeat (254) @(negedge clk);
    imem_ack = 1'b1; imem_rdata = W_ADDI;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("ackwin_trap", {31'd0, trap}, 32'd0);
    chk("ackwin_state", 32'(dut.r_state), 32'(S_DECODE));
    chk("ackwin_ir", instr, W_ADDI);

    // Fetch ack withheld 255 cycles traps
    do_reset();
    repeat (254) @(negedge clk);
    chk("to_pre_trap", {30'd0, imem_req, trap}, 32'b10);
    @(negedge clk);
    chk("to_trap", {30'd0, imem_req, trap}, 32'b01);
    chk("to_state", 32'(dut.r_state), 32'(S_STOP));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Parameter MEM_TIMEOUT, default 255, is the maximum wait cycles for a memory ack before trapping.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 imem_req  out  1  instruction fetch request.
REQ-006 imem_addr  out  32  fetch address, equals pc.
REQ-007 imem_ack  in  1  fetch data valid.
REQ-008 imem_rdata  in  32  fetched instruction word.
REQ-009 instr  out  32  latched instruction register (IR), drives the decoder.
REQ-010 alu_result  in  32  execute-stage result, also the load/store address.
REQ-011 branch_taken  in  1  branch condition from ALU, valid in EXEC.
REQ-012 target_addr  in  32  branch/JAL/JALR target, valid in EXEC.
REQ-013 dmem_req  out  1  data memory request.
REQ-014 dmem_we  out  1  1 = store, 0 = load.
REQ-015 dmem_ack  in  1  data access complete.
REQ-016 rf_we  out  1  register-file write strobe.
REQ-017 pc  out  32  current program counter.
REQ-018 instret  out  32  retired-instruction counter.
REQ-019 halt  out  1  sticky; set by ECALL/EBREAK.
REQ-020 trap  out  1  sticky; set by illegal opcode, misaligned target, or memory timeout.

Function
REQ-021 FSM states: FETCH, DECODE, EXEC, MEM, WB, STOP.
REQ-022 FETCH: imem_req=1 held; on imem_ack: IR<=imem_rdata, go to DECODE.
REQ-023 imem_addr stays stable while imem_req=1; ack outside FETCH/MEM is ignored.
REQ-024 DECODE: classify IR[6:0]; 1110011 sets halt and goes to STOP; unlisted opcode sets trap and goes to STOP; all others go to EXEC.
REQ-025 Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1101111, 1100111, 0110111, 0010111, 1100011, 1110011.
REQ-026 EXEC, load/store: go to MEM.
REQ-027 EXEC, branch: retire; pc<=target_addr if branch_taken, else pc+4; go to FETCH.
REQ-028 EXEC, any other opcode: go to WB.
REQ-029 MEM: dmem_req=1 held, dmem_we=1 for store.
REQ-030 MEM, on dmem_ack: load goes to WB; store retires with pc<=pc+4 and goes to FETCH.
REQ-031 WB: rf_we=1 for exactly one cycle, only if IR[11:7]!=0; retire.
REQ-032 WB PC update: JAL/JALR load pc<=target_addr; all others load pc<=pc+4; then go to FETCH.
REQ-033 Misaligned target: any redirected pc with bits[1:0]!=0 sets trap, goes to STOP, leaves pc unchanged and does not retire.
REQ-034 Retire: instret<=instret+1, wraps 32'hFFFF_FFFF to 0.
REQ-035 pc+4 wraps modulo 2^32.
REQ-036 Latency without wait states: 4 cycles for ALU/jump/branch-to-WB instructions; 3 for branches; 4 for stores; 5 for loads.
REQ-037 Timeout: a wait counter clears on entering FETCH or MEM, increments each cycle without ack, and sets trap and goes to STOP on reaching MEM_TIMEOUT.
REQ-038 STOP: all requests and strobes are 0 and pc/instret are frozen; only reset exits STOP.
REQ-039 Ack arriving in the same cycle the counter hits MEM_TIMEOUT: ack wins.

Reset
REQ-040 rst_n low asynchronously forces state FETCH, pc=RESET_PC, IR=0, instret=0, halt=0, trap=0, wait counter=0.
REQ-041 While rst_n is low, imem_req, dmem_req, dmem_we and rf_we are 0.
REQ-042 The first fetch request is issued the first rising edge after rst_n deasserts.
REQ-043 Reset mid-transaction abandons the pending request with no retirement or write.

Structure
REQ-044 Opcode constants (RTYPE, ITYPE, STYPE, UJTYPE, BTYPE, LOAD, JALR, LUI, AUIPC, SYSTEM) and FSM state encodings live in the shared define file.
REQ-045 The wait counter with its timeout compare is a sub-module named mem_watchdog.

Verification
REQ-046 Reset, then ADDI word with immediate ack -> imem_addr=0, rf_we pulse in cycle 4, pc=4, instret=1.
REQ-047 BEQ taken with target 0x40 -> no rf_we, pc=0x40 three cycles after fetch ack.
REQ-048 BEQ taken with target 0x42 -> trap=1, pc unchanged, instret unchanged.
REQ-049 LW with dmem_ack delayed 3 cycles -> dmem_req high for 4 cycles, dmem_we=0, one rf_we pulse, pc+=4.
REQ-050 imem_ack withheld 255 cycles -> trap=1, state STOP, imem_req=0.
REQ-051 ECALL (32'h0000_0073) -> halt=1, no retirement; then rst_n pulse -> pc=RESET_PC, halt=0.
